// File: rtl/led_seq_pkg.sv
// led_seq_pkg: pattern modes and per-mode seed patterns for the LED sequencer.
// Seeds are held 64 bits wide and truncated to LED_W by the user.
package led_seq_pkg;
    typedef enum logic [1:0] {
        MODE_WALK     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_COUNT    = 2'd2,
        MODE_ALT      = 2'd3
    } mode_e;

    localparam logic [63:0] SEED_ONE  = 64'h1;
    localparam logic [63:0] SEED_ZERO = 64'h0;
    localparam logic [63:0] SEED_ALT  = 64'h5555_5555_5555_5555;

    function automatic logic [63:0] seed_of(mode_e m);
        return (m == MODE_COUNT) ? SEED_ZERO : (m == MODE_ALT) ? SEED_ALT : SEED_ONE;
    endfunction
endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running PWM counter and brightness compare.
// Ports: i_clk, i_rst_n (async active-low), i_brightness (duty, all-ones = always on),
//        o_on (combinational on/off for the current counter value).
module led_pwm #(
    parameter int PWM_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PWM_W-1:0] i_brightness,
    output logic             o_on
);
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        o_on      = (&i_brightness) | (pwm_cnt_q < i_brightness);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pwm_cnt_q <= '0;
        else          pwm_cnt_q <= pwm_cnt_d;
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps an LED pattern on enable pulses with dwell/pause and PWM dimming.
// Ports: i_clk, i_rst_n (async active-low), i_step_en (1-cycle step pulse), i_mode (pattern mode),
//        i_dwell (enables per advance, 0 = 1), i_pause, i_brightness;
//        o_led (dimmed pattern), o_pattern (raw pattern), o_wrap (cycle-complete pulse), o_mode.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W   = 8,
    parameter int PWM_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_step_en,
    input  logic [1:0]         i_mode,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_pause,
    input  logic [PWM_W-1:0]   i_brightness,
    output logic [LED_W-1:0]   o_led,
    output logic [LED_W-1:0]   o_pattern,
    output logic               o_wrap,
    output logic [1:0]         o_mode
);
    mode_e              mode_q, mode_d, mode_in;
    logic [LED_W-1:0]   pattern_q, pattern_d, led_q, led_d, nxt, seed, alt;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d, dwell_max;
    logic [63:0]        seed64;
    logic               dir_q, dir_d, wrap_q, wrap_d, nxt_dir, nxt_wrap, pwm_on;

    led_pwm #(.PWM_W(PWM_W)) u_pwm (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_brightness (i_brightness),
        .o_on         (pwm_on)
    );

    // dir_q: 0 = moving toward MSB, 1 = moving toward LSB (ping-pong only)
    always_comb begin
        mode_in   = mode_e'(i_mode);
        seed64    = seed_of(mode_in);
        seed      = seed64[LED_W-1:0];
        alt       = SEED_ALT[LED_W-1:0];
        nxt       = pattern_q;
        nxt_dir   = dir_q;
        nxt_wrap  = 1'b0;
        case (mode_q)
            MODE_WALK: begin
                nxt      = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
                nxt_wrap = pattern_q[LED_W-1];
            end
            MODE_PINGPONG: begin
                if (!dir_q) begin
                    nxt     = pattern_q << 1;
                    nxt_dir = nxt[LED_W-1];
                end else begin
                    nxt      = pattern_q >> 1;
                    nxt_wrap = nxt[0];
                    nxt_dir  = ~nxt[0];
                end
            end
            MODE_COUNT: begin
                nxt      = pattern_q + LED_W'(1);
                nxt_wrap = &pattern_q;
            end
            default: begin
                nxt      = (pattern_q == alt) ? ~alt : alt;
                nxt_wrap = (pattern_q == ~alt);
            end
        endcase
        dwell_max   = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
        mode_d      = mode_q;
        pattern_d   = pattern_q;
        dir_d       = dir_q;
        dwell_cnt_d = dwell_cnt_q;
        wrap_d      = 1'b0;
        // a mode change reseeds and swallows any coincident step
        if (mode_in != mode_q) begin
            mode_d      = mode_in;
            pattern_d   = seed;
            dir_d       = 1'b0;
            dwell_cnt_d = '0;
        end else if (i_step_en && !i_pause) begin
            if (dwell_cnt_q >= dwell_max) begin
                dwell_cnt_d = '0;
                pattern_d   = nxt;
                dir_d       = nxt_dir;
                wrap_d      = nxt_wrap;
            end else begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end
        end
        led_d = pwm_on ? pattern_q : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q      <= MODE_WALK;
            pattern_q   <= LED_W'(1);
            dir_q       <= 1'b0;
            dwell_cnt_q <= '0;
            wrap_q      <= 1'b0;
            led_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            dir_q       <= dir_d;
            dwell_cnt_q <= dwell_cnt_d;
            wrap_q      <= wrap_d;
            led_q       <= led_d;
        end
    end

    assign o_led     = led_q;
    assign o_pattern = pattern_q;
    assign o_wrap    = wrap_q;
    assign o_mode    = mode_q;
endmodule
